// File: rtl/uart_baud_pkg.sv
// Shared constants and types for the fractional-N UART baud generator.
// Divisors are {integer, fraction} pairs; the fraction is in 1/16 cycle units.
package uart_baud_pkg;

  // Smallest integer divisor that still yields a one-cycle-wide pulse.
  localparam int DIV_MIN = 2;

  localparam int BAUD_INT_W  = 16;
  localparam int BAUD_FRAC_W = 4;

  typedef struct packed {
    logic [BAUD_INT_W-1:0]  int_part;
    logic [BAUD_FRAC_W-1:0] frac_part;
  } baud_div_t;

  // 115200 baud x16 oversampling at common system clocks.
  localparam baud_div_t DIV_50M_115K2X16  = '{int_part: 16'd27,  frac_part: 4'd2};  // 27.125
  localparam baud_div_t DIV_100M_115K2X16 = '{int_part: 16'd54,  frac_part: 4'd4};  // 54.25
  localparam baud_div_t DIV_200M_115K2X16 = '{int_part: 16'd108, frac_part: 4'd8};  // 108.5

  // Clamp an integer divisor to the supported minimum.
  function automatic int clamp_div_int(input int v);
    return (v < DIV_MIN) ? DIV_MIN : v;
  endfunction

  // Width of a modulo-os counter, never less than one bit.
  function automatic int os_cnt_width(input int os);
    return (os <= 2) ? 1 : $clog2(os);
  endfunction

endpackage

// File: rtl/uart_baud_os_div.sv
// Oversample-to-bit-rate divider: counts baud ticks modulo OVERSAMPLE and
// flags the tick on which the count wraps. Only built with UART_BAUD_1X_EN.
module uart_baud_os_div
  import uart_baud_pkg::*;
#(
  parameter int OVERSAMPLE = 16
)(
  input  logic clk_i,
  input  logic reset_i,
  input  logic tick_i,
  input  logic resync_i,
  output logic en_1x_o
);

  localparam int              OS_W    = os_cnt_width(OVERSAMPLE);
  localparam logic [OS_W-1:0] OS_LAST = OS_W'(OVERSAMPLE - 1);

  logic [OS_W-1:0] os_cnt_q, os_cnt_d;
  logic            en_1x_q, en_1x_d;

  // Next-state: resync restarts the count; each tick advances it with wrap.
  always_comb begin
    os_cnt_d = os_cnt_q;
    en_1x_d  = 1'b0;
    if (resync_i) begin
      os_cnt_d = '0;
    end else if (tick_i) begin
      en_1x_d  = (os_cnt_q == OS_LAST);
      os_cnt_d = (os_cnt_q == OS_LAST) ? '0 : os_cnt_q + OS_W'(1);
    end
  end

  // State and registered output.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      os_cnt_q <= '0;
      en_1x_q  <= 1'b0;
    end else begin
      os_cnt_q <= os_cnt_d;
      en_1x_q  <= en_1x_d;
    end
  end

  assign en_1x_o = en_1x_q;

endmodule

// File: rtl/uart_frac_baud_gen.sv
// Fractional-N baud-rate generator: emits a one-cycle oversample enable whose
// average period is a_int + a_frac/2^FRAC_W clocks. New divisors wait in a
// pending register and are adopted at the next tick (or resync), so a period
// in progress is never cut short. Define UART_BAUD_1X_EN to also generate the
// 1x bit-rate pulse; otherwise en_1x_baud_o is tied low.
module uart_frac_baud_gen
  import uart_baud_pkg::*;
#(
  parameter int INT_W      = BAUD_INT_W,
  parameter int FRAC_W     = BAUD_FRAC_W,
  parameter int OVERSAMPLE = 16,
  parameter int DEF_INT    = int'(DIV_100M_115K2X16.int_part),
  parameter int DEF_FRAC   = int'(DIV_100M_115K2X16.frac_part)
)(
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic              enable_i,
  input  logic [INT_W-1:0]  div_int_i,
  input  logic [FRAC_W-1:0] div_frac_i,
  input  logic              div_load_i,
  input  logic              resync_i,
  output logic              en_os_baud_o,
  output logic              en_1x_baud_o
);

  localparam int                CNT_W    = INT_W + 1;
  localparam logic [INT_W-1:0]  RST_INT  = INT_W'(clamp_div_int(DEF_INT));
  localparam logic [FRAC_W-1:0] RST_FRAC = FRAC_W'(DEF_FRAC);

  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [CNT_W-1:0]  per_q, per_d;
  logic [FRAC_W-1:0] acc_q, acc_d;
  logic [INT_W-1:0]  a_int_q, a_int_d;
  logic [FRAC_W-1:0] a_frac_q, a_frac_d;
  logic [INT_W-1:0]  p_int_q, p_int_d;
  logic [FRAC_W-1:0] p_frac_q, p_frac_d;
  logic              p_vld_q, p_vld_d;
  logic              en_os_q, en_os_d;

  logic [INT_W-1:0]  ld_int;
  logic [FRAC_W:0]   acc_sum;
  logic              tick;

  // Divisors below the minimum are clamped as they are captured.
  assign ld_int = (div_int_i < INT_W'(DIV_MIN)) ? INT_W'(DIV_MIN) : div_int_i;

  // Last enabled cycle of the current period; resync takes precedence.
  assign tick = enable_i & ~resync_i & (cnt_q == per_q - CNT_W'(1));

  // Next-state: resync restarts phase, tick closes a period, load fills pending.
  always_comb begin
    cnt_d    = cnt_q;
    per_d    = per_q;
    acc_d    = acc_q;
    a_int_d  = a_int_q;
    a_frac_d = a_frac_q;
    p_int_d  = p_int_q;
    p_frac_d = p_frac_q;
    p_vld_d  = p_vld_q;
    en_os_d  = 1'b0;
    acc_sum  = '0;
    if (resync_i) begin
      // A load in the same cycle is taken straight into the active divisor.
      if (div_load_i) begin
        a_int_d  = ld_int;
        a_frac_d = div_frac_i;
      end else if (p_vld_q) begin
        a_int_d  = p_int_q;
        a_frac_d = p_frac_q;
      end
      p_vld_d = 1'b0;
      cnt_d   = '0;
      acc_d   = '0;
      per_d   = {1'b0, a_int_d};
    end else begin
      if (tick) begin
        if (p_vld_q) begin
          a_int_d  = p_int_q;
          a_frac_d = p_frac_q;
          p_vld_d  = 1'b0;
        end
        // Fraction overflow lengthens the next period by one cycle.
        acc_sum = {1'b0, acc_q} + {1'b0, a_frac_d};
        acc_d   = acc_sum[FRAC_W-1:0];
        per_d   = {1'b0, a_int_d} + {{INT_W{1'b0}}, acc_sum[FRAC_W]};
        cnt_d   = '0;
        en_os_d = 1'b1;
      end else if (enable_i) begin
        cnt_d = cnt_q + CNT_W'(1);
      end
      // Captured after the tick so a coincident load waits for the next one.
      if (div_load_i) begin
        p_int_d  = ld_int;
        p_frac_d = div_frac_i;
        p_vld_d  = 1'b1;
      end
    end
  end

  // State registers with synchronous reset to the default divisor.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      cnt_q    <= '0;
      per_q    <= {1'b0, RST_INT};
      acc_q    <= '0;
      a_int_q  <= RST_INT;
      a_frac_q <= RST_FRAC;
      p_int_q  <= '0;
      p_frac_q <= '0;
      p_vld_q  <= 1'b0;
      en_os_q  <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      per_q    <= per_d;
      acc_q    <= acc_d;
      a_int_q  <= a_int_d;
      a_frac_q <= a_frac_d;
      p_int_q  <= p_int_d;
      p_frac_q <= p_frac_d;
      p_vld_q  <= p_vld_d;
      en_os_q  <= en_os_d;
    end
  end

  assign en_os_baud_o = en_os_q;

`ifdef UART_BAUD_1X_EN
  uart_baud_os_div #(
    .OVERSAMPLE (OVERSAMPLE)
  ) u_os_div (
    .clk_i    (clk_i),
    .reset_i  (reset_i),
    .tick_i   (tick),
    .resync_i (resync_i),
    .en_1x_o  (en_1x_baud_o)
  );
`else
  assign en_1x_baud_o = 1'b0;
`endif

endmodule
